// File: rtl/sha256_hex_serializer_if.sv
// ---------------------------------------------------------------------------
// sha256_hex_serializer_if
//   Groups the digest input handshake, the UART TX byte handshake and the job
//   status flags of the SHA-256 hex serializer.
//
//   Signals:
//     hash_in     digest word, captured on an accepted hash_valid
//     hash_valid  one-cycle strobe that starts a job
//     tx_busy     UART TX core busy
//     tx_start    one-cycle pulse: transmit tx_data
//     tx_data     ASCII character for the TX core
//     busy        job in progress
//     done        one-cycle pulse after the last character completes
//     overrun     sticky flag: a hash_valid arrived while a job was running
//
//   Modports:
//     master  the surrounding system (digest producer + TX core)
//     slave   the serializer itself
// ---------------------------------------------------------------------------
interface sha256_hex_serializer_if #(
    parameter int DIGEST_BITS = 256
);
    logic [DIGEST_BITS-1:0] hash_in;
    logic                   hash_valid;
    logic                   tx_busy;
    logic                   tx_start;
    logic [7:0]             tx_data;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    modport master (
        output hash_in,
        output hash_valid,
        output tx_busy,
        input  tx_start,
        input  tx_data,
        input  busy,
        input  done,
        input  overrun
    );

    modport slave (
        input  hash_in,
        input  hash_valid,
        input  tx_busy,
        output tx_start,
        output tx_data,
        output busy,
        output done,
        output overrun
    );
endinterface

// File: rtl/sha256_hex_serializer.sv
// ---------------------------------------------------------------------------
// sha256_hex_serializer
//   Captures a digest on a one-cycle hash_valid strobe and sends it to the
//   UART TX core as ASCII hex, most significant nibble first, one character
//   per tx_start/tx_busy handshake. A done pulse follows the last character.
//
//   Parameters:
//     DIGEST_BITS  digest width (multiple of 4); DIGEST_BITS/4 characters
//     UPPERCASE    0: letters 'a'-'f', 1: letters 'A'-'F'
//
//   Ports:
//     clk   clock
//     rst   asynchronous, active-high reset; aborts a running job silently
//     bus   sha256_hex_serializer_if.slave (digest in, TX handshake, status)
//
//   Build option:
//     HEX_SERIALIZER_CRLF_EN  when defined, every job ends with CR (0x0D)
//                             and LF (0x0A) after the hex characters.
// ---------------------------------------------------------------------------
module sha256_hex_serializer #(
    parameter int DIGEST_BITS = 256,
    parameter int UPPERCASE   = 0
) (
    input logic                  clk,
    input logic                  rst,
    sha256_hex_serializer_if.slave bus
);

    localparam int NCHARS = DIGEST_BITS / 4;
`ifdef HEX_SERIALIZER_CRLF_EN
    localparam int NTOTAL = NCHARS + 2;
`else
    localparam int NTOTAL = NCHARS;
`endif
    // Sized with headroom so the count can reach NTOTAL without wrapping.
    localparam int CNT_W = $clog2(NCHARS + 3) + 1;
    localparam logic [CNT_W-1:0] CNT_TOTAL = CNT_W'(NTOTAL);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef HEX_SERIALIZER_CRLF_EN
    localparam logic [CNT_W-1:0] CNT_NCHARS = CNT_W'(NCHARS);
`endif

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_FREE,
        FINISH
    } state_t;

    state_t                 state;
    logic [DIGEST_BITS-1:0] shift;
    logic [CNT_W-1:0]       count;
    logic [7:0]             next_char;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        logic [7:0] wide;
        wide = {4'h0, n};
        if (n < 4'd10)
            to_ascii = 8'h30 + wide;
        else
            to_ascii = ((UPPERCASE != 0) ? 8'h41 : 8'h61) + wide - 8'd10;
    endfunction

    // The top nibble of the shift register is always the next hex character;
    // with the line-terminator option the two extra slots after the hex run
    // are CR and LF.
    always_comb begin
        next_char = to_ascii(shift[DIGEST_BITS-1 -: 4]);
`ifdef HEX_SERIALIZER_CRLF_EN
        if (count == CNT_NCHARS)
            next_char = 8'h0D;
        else if (count > CNT_NCHARS)
            next_char = 8'h0A;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shift        <= '0;
            count        <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= 8'h00;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            bus.tx_start <= 1'b0;
            bus.done     <= 1'b0;

            // Any strobe outside IDLE (FINISH included) is dropped and flagged.
            if (bus.hash_valid && state != IDLE)
                bus.overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.hash_valid) begin
                        shift       <= bus.hash_in;
                        count       <= '0;
                        bus.overrun <= 1'b0;
                        bus.busy    <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (!bus.tx_busy) begin
                        bus.tx_data  <= next_char;
                        bus.tx_start <= 1'b1;
                        shift        <= {shift[DIGEST_BITS-5:0], 4'h0};
                        count        <= count + CNT_ONE;
                        state        <= WAIT_ACK;
                    end
                end

                // Wait for the TX core to show it took the byte before
                // looking for the end of its transmission.
                WAIT_ACK: begin
                    if (bus.tx_busy)
                        state <= WAIT_FREE;
                end

                WAIT_FREE: begin
                    if (!bus.tx_busy) begin
                        if (count == CNT_TOTAL) begin
                            bus.done <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end

                FINISH: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_hex_serializer.sv
// ---------------------------------------------------------------------------
// tb_sha256_hex_serializer
//   Drives a lowercase and an uppercase serializer from the same digest
//   stream. Each has its own UART TX model and its own expected-byte queue;
//   a monitor per instance pops and compares on every tx_start.
// ---------------------------------------------------------------------------
module tb_sha256_hex_serializer;

    localparam int DIGEST_BITS = 256;
    localparam int NCHARS      = DIGEST_BITS / 4;
    localparam logic [255:0] EMPTY_DIGEST =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DIGEST_BITS-1:0] hash_in_drv;
    logic                   hash_valid_drv;
    logic                   hold_busy;
    logic                   fixed_busy;

    sha256_hex_serializer_if #(.DIGEST_BITS(DIGEST_BITS)) bus_l ();
    sha256_hex_serializer_if #(.DIGEST_BITS(DIGEST_BITS)) bus_u ();

    sha256_hex_serializer #(.DIGEST_BITS(DIGEST_BITS), .UPPERCASE(0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    sha256_hex_serializer #(.DIGEST_BITS(DIGEST_BITS), .UPPERCASE(1)) dut_u (
        .clk (clk),
        .rst (rst),
        .bus (bus_u)
    );

    assign bus_l.hash_in    = hash_in_drv;
    assign bus_l.hash_valid = hash_valid_drv;
    assign bus_u.hash_in    = hash_in_drv;
    assign bus_u.hash_valid = hash_valid_drv;

    // UART TX models: a tx_start makes the core busy for a number of cycles
    // (10 in fixed mode, 1..4 otherwise); hold_busy forces busy externally.
    int busy_cnt_l;
    int busy_cnt_u;

    always @(posedge clk or posedge rst) begin
        if (rst)
            busy_cnt_l <= 0;
        else if (bus_l.tx_start)
            busy_cnt_l <= fixed_busy ? 10 : int'($urandom_range(4, 1));
        else if (busy_cnt_l > 0)
            busy_cnt_l <= busy_cnt_l - 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst)
            busy_cnt_u <= 0;
        else if (bus_u.tx_start)
            busy_cnt_u <= fixed_busy ? 10 : int'($urandom_range(4, 1));
        else if (busy_cnt_u > 0)
            busy_cnt_u <= busy_cnt_u - 1;
    end

    assign bus_l.tx_busy = (busy_cnt_l != 0) || hold_busy;
    assign bus_u.tx_busy = (busy_cnt_u != 0) || hold_busy;

    // Scoreboard state
    logic [7:0] exp_l[$];
    logic [7:0] exp_u[$];
    int n_checks  = 0;
    int n_fail    = 0;
    int sent_l    = 0;
    int sent_u    = 0;
    int done_cnt_l = 0;
    int done_cnt_u = 0;
    bit fall_seen_l = 1'b1;
    bit fall_seen_u = 1'b1;
    logic prev_busy_l = 1'b0;
    logic prev_busy_u = 1'b0;
    int fall_age_l = 0;
    int fall_age_u = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic logic [DIGEST_BITS-1:0] rand_digest();
        logic [DIGEST_BITS-1:0] r;
        for (int i = 0; i < DIGEST_BITS / 32; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: a job is the digest printed as a 64-digit hex string
    // (lowercase, or upper-cased), optionally followed by CR LF.
    task automatic applyStimulus(input logic [DIGEST_BITS-1:0] d);
        string s_lo;
        string s_up;
        s_lo = $sformatf("%064h", d);
        s_up = s_lo.toupper();
        for (int i = 0; i < NCHARS; i++) begin
            exp_l.push_back(s_lo[i]);
            exp_u.push_back(s_up[i]);
        end
`ifdef HEX_SERIALIZER_CRLF_EN
        exp_l.push_back(8'h0D);
        exp_l.push_back(8'h0A);
        exp_u.push_back(8'h0D);
        exp_u.push_back(8'h0A);
`endif
        hash_in_drv    = d;
        hash_valid_drv = 1'b1;
        @(negedge clk);
        hash_valid_drv = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int cyc;
        cyc = 0;
        while ((done_cnt_l < target || done_cnt_u < target) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, "_done_l"}, done_cnt_l, target);
        checkOutput({name, "_done_u"}, done_cnt_u, target);
    endtask

    task automatic wait_sent(input int target, input string name);
        int cyc;
        cyc = 0;
        while (sent_l < target && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, "_reached"}, sent_l, target);
    endtask

    // Monitor for the lowercase instance
    initial begin
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (bus_l.tx_start) begin
                sent_l++;
                checkOutput("start_after_busy_fall_l", fall_seen_l, 1);
                fall_seen_l = 1'b0;
                if (exp_l.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_byte_l: got 0x%0h, expected no byte at %0t",
                             bus_l.tx_data, $time);
                end else begin
                    checkOutput("byte_l", bus_l.tx_data, exp_l.pop_front());
                end
            end
            if (prev_busy_l && !bus_l.tx_busy) begin
                fall_seen_l = 1'b1;
                fall_age_l  = 0;
            end else begin
                fall_age_l++;
            end
            prev_busy_l = bus_l.tx_busy;
            if (bus_l.done) begin
                done_cnt_l++;
                checkOutput("done_bytes_left_l", exp_l.size(), 0);
                checkOutput("done_after_fall_l", fall_age_l, 1);
            end
        end
    end

    // Monitor for the uppercase instance
    initial begin
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (bus_u.tx_start) begin
                sent_u++;
                checkOutput("start_after_busy_fall_u", fall_seen_u, 1);
                fall_seen_u = 1'b0;
                if (exp_u.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_byte_u: got 0x%0h, expected no byte at %0t",
                             bus_u.tx_data, $time);
                end else begin
                    checkOutput("byte_u", bus_u.tx_data, exp_u.pop_front());
                end
            end
            if (prev_busy_u && !bus_u.tx_busy) begin
                fall_seen_u = 1'b1;
                fall_age_u  = 0;
            end else begin
                fall_age_u++;
            end
            prev_busy_u = bus_u.tx_busy;
            if (bus_u.done) begin
                done_cnt_u++;
                checkOutput("done_bytes_left_u", exp_u.size(), 0);
                checkOutput("done_after_fall_u", fall_age_u, 1);
            end
        end
    end

    initial begin
        int starts;
        int base;
        rst            = 1'b1;
        hash_in_drv    = '0;
        hash_valid_drv = 1'b0;
        hold_busy      = 1'b0;
        fixed_busy     = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_tx_start", bus_l.tx_start, 0);
        checkOutput("reset_tx_data",  bus_l.tx_data, 8'h00);
        checkOutput("reset_busy",     bus_l.busy, 0);
        checkOutput("reset_done",     bus_l.done, 0);
        checkOutput("reset_overrun",  bus_l.overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // Empty-message digest with a 10-cycle TX core; first byte timing.
        $display("[TB] job 1: empty-message digest");
        applyStimulus(EMPTY_DIGEST);
        checkOutput("busy_after_accept", bus_l.busy, 1);
        checkOutput("no_start_one_cycle", bus_l.tx_start, 0);
        @(negedge clk);
        checkOutput("first_start_latency_l", bus_l.tx_start, 1);
        checkOutput("first_char_l", bus_l.tx_data, 8'h65);
        checkOutput("first_start_latency_u", bus_u.tx_start, 1);
        checkOutput("first_char_u", bus_u.tx_data, 8'h45);
        wait_done(1, "job1");
        @(negedge clk);
        checkOutput("busy_idle_job1", bus_l.busy, 0);
        fixed_busy = 1'b0;

        // All ones then all zeros, busy must drop in between.
        $display("[TB] jobs 2-3: all-F then all-0");
        applyStimulus({DIGEST_BITS{1'b1}});
        wait_done(2, "job2");
        @(negedge clk);
        checkOutput("busy_between_jobs_l", bus_l.busy, 0);
        checkOutput("busy_between_jobs_u", bus_u.busy, 0);
        applyStimulus({DIGEST_BITS{1'b0}});
        wait_done(3, "job3");
        @(negedge clk);

        // TX core busy for 50 cycles at job start.
        $display("[TB] job 4: tx_busy held at start");
        hold_busy = 1'b1;
        applyStimulus(rand_digest());
        starts = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus_l.tx_start || bus_u.tx_start) starts++;
        end
        checkOutput("no_start_while_held", starts, 0);
        hold_busy = 1'b0;
        wait_done(4, "job4");
        @(negedge clk);

        // Second strobe at char 10 must be ignored and flagged.
        $display("[TB] job 5: overrun");
        base = sent_l;
        applyStimulus(rand_digest());
        wait_sent(base + 10, "overrun_char10");
        hash_in_drv    = rand_digest();
        hash_valid_drv = 1'b1;
        @(negedge clk);
        hash_valid_drv = 1'b0;
        hash_in_drv    = rand_digest();
        checkOutput("overrun_set_l", bus_l.overrun, 1);
        checkOutput("overrun_set_u", bus_u.overrun, 1);
        wait_done(5, "job5");
        @(negedge clk);
        checkOutput("overrun_sticky", bus_l.overrun, 1);

        // Next job clears overrun; reset at char 30 aborts it.
        $display("[TB] job 6: reset mid-job");
        base = sent_l;
        applyStimulus(rand_digest());
        checkOutput("overrun_cleared", bus_l.overrun, 0);
        wait_sent(base + 30, "reset_char30");
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_tx_start_l", bus_l.tx_start, 0);
        checkOutput("abort_busy_l", bus_l.busy, 0);
        checkOutput("abort_busy_u", bus_u.busy, 0);
        repeat (2) @(negedge clk);
        exp_l.delete();
        exp_u.delete();
        fall_seen_l = 1'b1;
        fall_seen_u = 1'b1;
        prev_busy_l = 1'b0;
        prev_busy_u = 1'b0;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("no_done_after_abort_l", done_cnt_l, 5);
        checkOutput("no_done_after_abort_u", done_cnt_u, 5);

        // Fresh job after reset starts from the first character.
        $display("[TB] job 7: after reset");
        applyStimulus(rand_digest());
        wait_done(6, "job7");
        repeat (5) @(negedge clk);
        checkOutput("final_queue_l", exp_l.size(), 0);
        checkOutput("final_queue_u", exp_u.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
